apb_master_multi: RTL and testbench
===================================

APB_MASTER_MULTI -- requirements
Module: apb_master_multi

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width; legal values are 8, 16 and 32.
REQ-003 The block SHALL have parameter NSLV, default 4, meaning the number of slaves; legal range is 1 to 8.
REQ-004 The block SHALL have parameter SPAN_LOG2, default 12, meaning log2 of the byte window per slave.
REQ-005 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS wait cycles; legal range is 1 to 255.

Interface
REQ-006 PCLK  in  1  single clock; all logic on rising edge.
REQ-007 PRESET  in  1  reset, asynchronous, active-high.
REQ-008 req_valid  in  1  user request present.
REQ-009 req_ready  out  1  block can accept a request.
REQ-010 req_write  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  DATA_W  write data.
REQ-013 req_strb  in  DATA_W/8  write byte strobes.
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_rdata  out  DATA_W  read data.
REQ-016 rsp_resp  out  2  response: 00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT.
REQ-017 PSEL  out  NSLV  one-hot slave select.
REQ-018 PENABLE, PWRITE  out  1 each  APB enable and direction.
REQ-019 PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8.
REQ-020 PRDATA  in  NSLV*DATA_W  per-slave read data; slave k occupies bits [k*DATA_W +: DATA_W].
REQ-021 PREADY, PSLVERR  in  NSLV each  per-slave ready and error.

Function
REQ-022 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
REQ-024 On acceptance, the address, direction, data and strobes SHALL be registered; later changes to the req_* inputs have no effect on that transfer.
REQ-025 Decode: idx = addr[SPAN_LOG2 +: clog2(NSLV)]; for NSLV=1, idx = 0.
REQ-026 Decode error: if any addr bit at or above SPAN_LOG2+clog2(NSLV) is 1, or idx >= NSLV, the block SHALL issue no APB cycle, pulse rsp_valid in the next cycle with resp = 10, and return to IDLE.
REQ-027 Misalignment: if the address is not aligned to DATA_W/8, the block SHALL respond as in REQ-026 with resp = 10.
REQ-028 SETUP lasts exactly one cycle: PSEL[idx] = 1, PENABLE = 0, and PADDR/PWRITE/PWDATA/PSTRB are valid.
REQ-029 ACCESS: PENABLE = 1, and all APB outputs are held stable until the transfer completes.
REQ-030 Completion: the transfer SHALL complete at the edge where PREADY[idx] = 1 in ACCESS.
REQ-031 At completion, the block SHALL capture PRDATA slice idx for reads (0 for writes) and set resp = PSLVERR[idx] ? 01 : 00.
REQ-032 After completion, the block SHALL pulse rsp_valid for the next cycle, drop PSEL/PENABLE, and go to IDLE.
REQ-033 Latency SHALL be 3 cycles minimum from acceptance edge to rsp_valid (zero-wait slave).
REQ-034 Back-to-back requests are allowed; req_ready is high in the same cycle as rsp_valid.
REQ-035 Timeout: a counter SHALL count ACCESS cycles with PREADY[idx] = 0.
REQ-036 When that counter reaches TIMEOUT, the block SHALL abort the transfer: deassert PSEL/PENABLE, pulse rsp_valid with resp = 11 and rsp_rdata = 0, and go to IDLE.
REQ-037 The timeout counter SHALL clear on every acceptance.
REQ-038 The block SHALL ignore PREADY, PSLVERR and PRDATA of unselected slaves, and of all slaves outside ACCESS.
REQ-039 When the transfer is a write, PSTRB SHALL carry req_strb; when it is a read, PSTRB SHALL be 0.
REQ-040 rsp_rdata and rsp_resp SHALL hold their last values between pulses.
REQ-041 PSEL SHALL never have more than one bit set.

Reset
REQ-042 While PRESET = 1, regardless of PCLK: FSM = IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_resp and the counter are 0; req_ready = 0.
REQ-043 Reset mid-transfer SHALL abort that transfer with no rsp_valid pulse.
REQ-044 req_ready SHALL rise on the first rising edge after PRESET deasserts.

Verification (defaults, NSLV=4, zero-wait slave model unless stated)
REQ-045 Write 0x17 to 0x0, then read 0x0 -> APB write to PSEL=0001 with PSTRB=F; read returns rdata = 0x17, resp = 00; rsp_valid 3 cycles after each acceptance.
REQ-046 Write 0x15112023 to 0x1004 and 0x4C594150 to 0x2008, then read both back -> PSEL = 0010 and 0100 respectively; rdata matches; no overlap between transfers.
REQ-047 Slave 3 (0x3000) holds PREADY low for 5 cycles, then PSLVERR = 1 -> ACCESS lasts 6 cycles; APB outputs stable throughout; resp = 01.
REQ-048 Slave 1 never ready -> abort after 16 ACCESS cycles; resp = 11, rdata = 0; next request accepted normally.
REQ-049 Address 0x4000 and address 0x0002 -> no PSEL activity; resp = 10 one cycle after acceptance.
REQ-050 PRESET asserted in ACCESS -> all outputs 0 immediately; no rsp_valid pulse; after release, a read of 0x0 completes with resp = 00.

Source files
------------

// File: rtl/apb_master_multi.sv
// APB master with one-hot select over NSLV slaves, each occupying a 2**SPAN_LOG2 byte window.
// Accepts one request at a time; decode errors answer directly, stalled slaves are cut off after TIMEOUT.
module apb_master_multi #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NSLV      = 4,
  parameter int SPAN_LOG2 = 12,
  parameter int TIMEOUT   = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/8-1:0]      req_strb,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic [NSLV-1:0]          PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  output logic [DATA_W/8-1:0]      PSTRB,
  input  logic [NSLV*DATA_W-1:0]   PRDATA,
  input  logic [NSLV-1:0]          PREADY,
  input  logic [NSLV-1:0]          PSLVERR,
  output logic [1:0]               dbg_state
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int IDX_BITS = (NSLV > 1) ? $clog2(NSLV) : 0;
  localparam int IDX_W    = (NSLV > 1) ? IDX_BITS : 1;
  localparam int HI_BIT   = SPAN_LOG2 + IDX_BITS;
  localparam int ALIGN    = $clog2(STRB_W);

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b01;
  localparam logic [1:0] RESP_DECERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                run_q;
  logic [IDX_W-1:0]    idx_q;
  logic [7:0]          tcnt_q;

  logic [IDX_W-1:0]    req_idx;
  logic                dec_err;
  logic                accept;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tout_hit;

  // Address decode of the incoming request: out-of-range bits, bad slave index, misalignment.
  always_comb begin
    req_idx = '0;
    dec_err = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (i >= HI_BIT && req_addr[i]) dec_err = 1'b1;
    end
    for (int i = 0; i < ALIGN; i++) begin
      if (req_addr[i]) dec_err = 1'b1;
    end
    for (int b = 0; b < IDX_BITS; b++) begin
      req_idx[b] = req_addr[SPAN_LOG2+b];
    end
    if (int'(req_idx) >= NSLV) dec_err = 1'b1;
  end

  // Only the addressed slave's response is ever looked at.
  always_comb begin
    sel_ready = PREADY[idx_q];
    sel_err   = PSLVERR[idx_q];
    sel_rdata = PRDATA[idx_q*DATA_W +: DATA_W];
  end

  assign req_ready = (state_q == IDLE) && run_q;
  assign accept    = req_valid && req_ready;
  assign tout_hit  = !sel_ready && (tcnt_q == 8'(TIMEOUT - 1));
  assign dbg_state = state_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    PSEL    = '0;
    PENABLE = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !dec_err) state_d = SETUP;
      end
      SETUP: begin
        PSEL    = NSLV'(1) << idx_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = NSLV'(1) << idx_q;
        PENABLE = 1'b1;
        if (sel_ready || tout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      run_q     <= 1'b0;
      idx_q     <= '0;
      tcnt_q    <= '0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      run_q     <= 1'b1;
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            tcnt_q <= '0;
            if (dec_err) begin
              // Rejected requests never touch the bus; answer on the next cycle.
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_resp  <= RESP_DECERR;
            end else begin
              idx_q  <= req_idx;
              PWRITE <= req_write;
              PADDR  <= req_addr;
              PWDATA <= req_wdata;
              PSTRB  <= req_write ? req_strb : '0;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : sel_rdata;
            rsp_resp  <= sel_err ? RESP_SLVERR : RESP_OKAY;
          end else if (tout_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_TIMEOUT;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_multi.sv
// Directed bench for apb_master_multi with four configurable APB slave models.
module tb_apb_master_multi;

  logic        PCLK;
  logic        PRESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]  PREADY;
  logic [3:0]  PSLVERR;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave models: word memory, programmable wait states, hang and error flags.
  logic [31:0] mem [0:3][0:15];
  int          wait_cfg [0:3];
  logic [3:0]  hang;
  logic [3:0]  err_cfg;
  int          acc_cnt;

  apb_master_multi dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  for (genvar k = 0; k < 4; k++) begin : g_slv
    assign PRDATA[k*32 +: 32] = mem[k][PADDR[5:2]];
    assign PREADY[k]  = !hang[k] && (acc_cnt >= wait_cfg[k]);
    assign PSLVERR[k] = err_cfg[k];
  end

  always @(posedge PCLK) begin
    if (PSEL != 4'b0 && PENABLE) acc_cnt <= acc_cnt + 1;
    else                         acc_cnt <= 0;
    for (int k = 0; k < 4; k++) begin
      if (PSEL[k] && PENABLE && PREADY[k] && PWRITE) begin
        for (int b = 0; b < 4; b++) begin
          if (PSTRB[b]) mem[k][PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one request, then follow it through SETUP/ACCESS to the response pulse.
  // exp_psel == 0 means a decode error is expected.
  task automatic do_xfer(input string tag, input logic w, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [3:0] exp_psel, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_resp, input int exp_acc);
    int   acc;
    logic done;
    @(negedge PCLK);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'hDEAD_BEEF;
    req_strb  = 4'h0;
    if (exp_psel == 4'b0) begin
      check({tag, " decerr_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " decerr_resp"},  32'(rsp_resp), 32'(exp_resp));
      check({tag, " decerr_psel"},  32'(PSEL), 32'd0);
      check({tag, " decerr_ready"}, 32'(req_ready), 32'd1);
      @(negedge PCLK);
      check({tag, " decerr_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, " decerr_psel2"}, 32'(PSEL), 32'd0);
    end else begin
      check({tag, " setup_psel"},   32'(PSEL), 32'(exp_psel));
      check({tag, " setup_pen"},    32'(PENABLE), 32'd0);
      check({tag, " setup_state"},  32'(dbg_state), 32'd1);
      check({tag, " setup_paddr"},  PADDR, addr);
      check({tag, " setup_pwrite"}, 32'(PWRITE), 32'(w));
      check({tag, " setup_pstrb"},  32'(PSTRB), w ? 32'(strb) : 32'd0);
      if (w) check({tag, " setup_pwdata"}, PWDATA, wdata);
      acc  = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
        @(negedge PCLK);
        if (rsp_valid) done = 1'b1;
        else begin
          acc++;
          check({tag, " acc_pen"},   32'(PENABLE), 32'd1);
          check({tag, " acc_psel"},  32'(PSEL), 32'(exp_psel));
          check({tag, " acc_paddr"}, PADDR, addr);
          check({tag, " acc_pstrb"}, 32'(PSTRB), w ? 32'(strb) : 32'd0);
        end
      end
      check({tag, " done"},      32'(done), 32'd1);
      check({tag, " acc_len"},   32'(acc), 32'(exp_acc));
      check({tag, " rdata"},     rsp_rdata, exp_rdata);
      check({tag, " resp"},      32'(rsp_resp), 32'(exp_resp));
      check({tag, " rsp_ready"}, 32'(req_ready), 32'd1);
      check({tag, " rsp_psel"},  32'(PSEL), 32'd0);
      check({tag, " rsp_pen"},   32'(PENABLE), 32'd0);
      @(negedge PCLK);
      check({tag, " pulse"},     32'(rsp_valid), 32'd0);
      check({tag, " hold_rdata"}, rsp_rdata, exp_rdata);
      check({tag, " hold_resp"}, 32'(rsp_resp), 32'(exp_resp));
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) wait_cfg[k] = 0;
    hang      = 4'b0;
    err_cfg   = 4'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_strb  = 4'h0;
    PRESET    = 1'b1;
    #1;
    check("rst ready",  32'(req_ready), 32'd0);
    check("rst psel",   32'(PSEL), 32'd0);
    check("rst valid",  32'(rsp_valid), 32'd0);
    check("rst state",  32'(dbg_state), 32'd0);
    check("rst paddr",  PADDR, 32'd0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    check("rel ready_lo", 32'(req_ready), 32'd0);
    @(negedge PCLK);
    check("rel ready_hi", 32'(req_ready), 32'd1);

    // Basic write / read on slave 0
    do_xfer("w0",  1'b1, 32'h0000_0000, 32'h0000_0017, 4'hF, 4'b0001, 32'h0, 2'b00, 1);
    do_xfer("r0",  1'b0, 32'h0000_0000, 32'h0,         4'hF, 4'b0001, 32'h17, 2'b00, 1);

    // Slaves 1 and 2
    do_xfer("w1",  1'b1, 32'h0000_1004, 32'h1511_2023, 4'hF, 4'b0010, 32'h0, 2'b00, 1);
    do_xfer("w2",  1'b1, 32'h0000_2008, 32'h4C59_4150, 4'hF, 4'b0100, 32'h0, 2'b00, 1);
    do_xfer("r1",  1'b0, 32'h0000_1004, 32'h0,         4'hF, 4'b0010, 32'h1511_2023, 2'b00, 1);
    do_xfer("r2",  1'b0, 32'h0000_2008, 32'h0,         4'hF, 4'b0100, 32'h4C59_4150, 2'b00, 1);

    // Slave 1 hangs: abort after 16 ACCESS cycles, then recover
    hang[1] = 1'b1;
    do_xfer("tout", 1'b0, 32'h0000_1000, 32'h0, 4'hF, 4'b0010, 32'h0, 2'b11, 16);
    hang[1] = 1'b0;
    do_xfer("after_tout", 1'b0, 32'h0000_1004, 32'h0, 4'hF, 4'b0010, 32'h1511_2023, 2'b00, 1);

    // Slave 3 waits 5 cycles then errors
    wait_cfg[3] = 5;
    err_cfg[3]  = 1'b1;
    do_xfer("slverr", 1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, 4'b1000, 32'h0, 2'b01, 6);
    wait_cfg[3] = 0;
    err_cfg[3]  = 1'b0;

    // Decode errors
    do_xfer("dec_hi",  1'b0, 32'h0000_4000, 32'h0, 4'hF, 4'b0000, 32'h0, 2'b10, 0);
    do_xfer("dec_mis", 1'b1, 32'h0000_0002, 32'h55, 4'hF, 4'b0000, 32'h0, 2'b10, 0);

    // Reset during ACCESS
    wait_cfg[0] = 10;
    @(negedge PCLK);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    check("mid access", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    #1;
    check("mid psel",   32'(PSEL), 32'd0);
    check("mid pen",    32'(PENABLE), 32'd0);
    check("mid paddr",  PADDR, 32'd0);
    check("mid pwrite", 32'(PWRITE), 32'd0);
    check("mid pwdata", PWDATA, 32'd0);
    check("mid pstrb",  32'(PSTRB), 32'd0);
    check("mid valid",  32'(rsp_valid), 32'd0);
    check("mid rdata",  rsp_rdata, 32'd0);
    check("mid resp",   32'(rsp_resp), 32'd0);
    check("mid ready",  32'(req_ready), 32'd0);
    check("mid state",  32'(dbg_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("mid no_pulse", 32'(rsp_valid), 32'd0);
    end
    PRESET = 1'b0;
    #1;
    check("mid rel_lo", 32'(req_ready), 32'd0);
    check("mid no_pulse2", 32'(rsp_valid), 32'd0);
    @(negedge PCLK);
    check("mid rel_hi", 32'(req_ready), 32'd1);
    check("mid no_pulse3", 32'(rsp_valid), 32'd0);
    wait_cfg[0] = 0;
    do_xfer("post_rst", 1'b0, 32'h0000_0000, 32'h0, 4'hF, 4'b0001, 32'h17, 2'b00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
